miriscv_mem_stage: RTL
======================

// Module: miriscv_mem_stage
// PURPOSE
//  Memory/commit stage directly downstream of the execute ALU. Consumes the ALU result and branch
//  decision, issues a redirect for taken branches and jumps, and performs loads/stores on the
//  data bus (req/gnt/rvalid). It also byte-aligns load data, sign- or zero-extends it, and
//  produces one writeback beat per accepted instruction.
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported (byte lanes fixed at 4)
// PORTS
//  clk_i            in   1       clock; all state updates on rising edge
//  rst_i            in   1       synchronous, active-high reset
//  ex_valid_i       in   1       execute stage presents an instruction
//  ex_ready_o       out  1       stage can accept (state==IDLE)
//  ex_alu_result_i  in   XLEN    ALU result: wb value, or effective address for mem ops
//  ex_branch_des_i  in   1       ALU branch decision
//  ex_is_branch_i   in   1       conditional branch
//  ex_is_jump_i     in   1       unconditional jump (JAL/JALR)
//  ex_target_pc_i   in   XLEN    branch/jump target
//  ex_rd_addr_i     in   5       destination register
//  ex_rd_we_i       in   1       instruction writes rd
//  ex_mem_req_i     in   1       load/store instruction
//  ex_mem_we_i      in   1       1=store, 0=load
//  ex_mem_size_i    in   2       0=byte 1=half 2=word 3=illegal
//  ex_mem_sext_i    in   1       sign-extend load data
//  ex_store_data_i  in   XLEN    store data (rs2)
//  redirect_o       out  1       one-cycle pulse: fetch must restart at redirect_pc_o
//  redirect_pc_o    out  XLEN    redirect target
//  data_req_o       out  1       data bus request
//  data_gnt_i       in   1       request accepted
//  data_rvalid_i    in   1       response valid
//  data_we_o        out  1       write enable
//  data_be_o        out  4       byte enables
//  data_addr_o      out  XLEN    word-aligned address ({addr[31:2],2'b00})
//  data_wdata_o     out  XLEN    lane-replicated store data
//  data_rdata_i     in   XLEN    read data
//  mem_misalign_o   out  1       one-cycle pulse: misaligned/illegal access dropped
//  wb_valid_o       out  1       one-cycle writeback beat (no backpressure)
//  wb_rd_we_o       out  1       register write enable for this beat
//  wb_rd_addr_o     out  5       destination register
//  wb_data_o        out  XLEN    writeback data
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0 except ex_ready_o=1. Reset mid-transaction returns to
//    IDLE and drops data_req_o immediately; the bench resets the memory model with it.
//  - Accept = ex_valid_i & ex_ready_o. FSM: IDLE -> (mem op, aligned) REQ -> WAIT -> IDLE.
//  - Non-mem accepted in cycle N: wb_valid_o=1 at N+1 with wb_data_o=ex_alu_result_i.
//    The stage stays in IDLE, so throughput is 1 instruction per cycle.
//  - Redirect: an accept with ex_is_jump_i | (ex_is_branch_i & ex_branch_des_i) gives
//    redirect_o=1 at N+1 with redirect_pc_o=ex_target_pc_i. ex_branch_des_i is ignored
//    when ex_is_branch_i=0.
//  - Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size 3. The stage issues no
//    request, pulses mem_misalign_o at N+1 and gives wb_valid_o=1 with wb_rd_we_o=0 at N+1.
//  - REQ: data_req_o=1 with latched addr/we/be/wdata held stable until the data_gnt_i cycle,
//    then WAIT. data_rvalid_i is only legal after gnt; it is ignored in IDLE/REQ.
//  - WAIT: on data_rvalid_i at cycle R -> IDLE; wb_valid_o=1 at R+1 and ex_ready_o=1 at R+1.
//    Loads: wb_rd_we_o=latched rd_we. Stores: wb_rd_we_o=0.
//  - Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111.
//    Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  - Load extraction: select the lane rdata>>(8*a[1:0]), then sign/zero-extend from
//    8 or 16 bits; word is passed unchanged.
//  - wb_valid_o, redirect_o and mem_misalign_o are registered pulses that never stay high
//    2 cycles without a new accept. Outputs hold their last value while wb_valid_o=0.
// TESTING
//  1 ADD result 0x1234, rd=5, accept N -> wb_valid_o@N+1, wb_data_o=0x1234, rd 5, we=1;
//    back-to-back accepts every cycle.
//  2 BEQ branch_des=1, target 0x80 -> redirect_o@N+1, pc 0x80; with branch_des=0 -> no redirect.
//  3 LB addr 0x103, sext, gnt after 2 wait cycles, rdata 0x80FFFFFF -> be 4'b1000,
//    addr 0x100, wb_data 0xFFFFFF80; with LBU -> 0x00000080.
//  4 SH addr 0x202, data 0xABCD1234 -> be 4'b1100, wdata 0x12341234, we=1;
//    wb_rd_we_o=0; req held stable while gnt=0.
//  5 LW addr 0x101 -> no data_req_o, mem_misalign_o@N+1, wb_valid_o@N+1 with wb_rd_we_o=0.
//  6 rst_i asserted in WAIT -> next cycle data_req_o=0, wb_valid_o=0, ex_ready_o=1;
//    a late rvalid is ignored.

Source files
------------

// File: rtl/miriscv_mem_stage.sv
// Memory/commit stage of the miriscv pipeline.
// Takes the execute-stage result and either retires it directly (ALU ops,
// branches, jumps) or runs one load/store on the req/gnt/rvalid data bus.
// Taken branches and jumps produce a one-cycle redirect pulse, and loads are
// lane-aligned and sign/zero-extended before the writeback beat.
//
// Handshakes:
//   ex side  : an instruction transfers on a rising edge where
//              ex_valid_i & ex_ready_o are both high; ex_ready_o is high
//              exactly when the stage is idle.
//   data bus : data_req_o and its address/we/be/wdata stay stable until the
//              edge where data_gnt_i is high. data_rvalid_i is honoured only
//              after that grant (WAIT state) and is ignored otherwise.
//   writeback: wb_valid_o is a one-cycle beat with no backpressure. The wb_*
//              fields hold their last value while wb_valid_o is low.
module miriscv_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic            ex_branch_des_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jump_i,
  input  logic [XLEN-1:0] ex_target_pc_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_rd_we_i,
  input  logic            ex_mem_req_i,
  input  logic            ex_mem_we_i,
  input  logic [1:0]      ex_mem_size_i,
  input  logic            ex_mem_sext_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            data_req_o,
  input  logic            data_gnt_i,
  input  logic            data_rvalid_i,
  output logic            data_we_o,
  output logic [3:0]      data_be_o,
  output logic [XLEN-1:0] data_addr_o,
  output logic [XLEN-1:0] data_wdata_o,
  input  logic [XLEN-1:0] data_rdata_i,
  output logic            mem_misalign_o,
  output logic            wb_valid_o,
  output logic            wb_rd_we_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_data_o
);

  // Transaction FSM; state_q is the observable state for checkers.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t state_q;

  // Attributes of the in-flight memory op, needed when the response arrives.
  logic       lat_we;
  logic [1:0] lat_size;
  logic       lat_sext;
  logic [1:0] lat_off;
  logic [4:0] lat_rd;
  logic       lat_rd_we;

  logic            accept;
  logic            take_redirect;
  logic            misaligned;
  logic [3:0]      be_calc;
  logic [XLEN-1:0] wdata_calc;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_data;

  assign ex_ready_o    = (state_q == ST_IDLE);
  assign accept        = ex_valid_i & ex_ready_o;
  assign take_redirect = ex_is_jump_i | (ex_is_branch_i & ex_branch_des_i);

  // Decode the incoming access: alignment, byte enables, lane-replicated store data.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = ex_store_data_i;
    misaligned = 1'b0;
    case (ex_mem_size_i)
      2'd0: begin
        be_calc    = 4'b0001 << ex_alu_result_i[1:0];
        wdata_calc = {4{ex_store_data_i[7:0]}};
      end
      2'd1: begin
        be_calc    = 4'b0011 << ex_alu_result_i[1:0];
        wdata_calc = {2{ex_store_data_i[15:0]}};
        misaligned = ex_alu_result_i[0];
      end
      2'd2: begin
        misaligned = |ex_alu_result_i[1:0];
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0 and extend it to the full width.
  always_comb begin
    lane      = data_rdata_i >> {lat_off, 3'b000};
    load_data = data_rdata_i;
    case (lat_size)
      2'd0:    load_data = {{(XLEN-8){lat_sext & lane[7]}}, lane[7:0]};
      2'd1:    load_data = {{(XLEN-16){lat_sext & lane[15]}}, lane[15:0]};
      default: load_data = data_rdata_i;
    endcase
  end

  // FSM plus all registered outputs; pulses default low every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      redirect_o     <= 1'b0;
      redirect_pc_o  <= '0;
      data_req_o     <= 1'b0;
      data_we_o      <= 1'b0;
      data_be_o      <= 4'b0000;
      data_addr_o    <= '0;
      data_wdata_o   <= '0;
      mem_misalign_o <= 1'b0;
      wb_valid_o     <= 1'b0;
      wb_rd_we_o     <= 1'b0;
      wb_rd_addr_o   <= 5'd0;
      wb_data_o      <= '0;
      lat_we         <= 1'b0;
      lat_size       <= 2'd0;
      lat_sext       <= 1'b0;
      lat_off        <= 2'd0;
      lat_rd         <= 5'd0;
      lat_rd_we      <= 1'b0;
    end else begin
      redirect_o     <= 1'b0;
      mem_misalign_o <= 1'b0;
      wb_valid_o     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (take_redirect) begin
              redirect_o    <= 1'b1;
              redirect_pc_o <= ex_target_pc_i;
            end
            if (ex_mem_req_i) begin
              if (misaligned) begin
                // Dropped access still retires, but never writes rd.
                mem_misalign_o <= 1'b1;
                wb_valid_o     <= 1'b1;
                wb_rd_we_o     <= 1'b0;
                wb_rd_addr_o   <= ex_rd_addr_i;
              end else begin
                state_q      <= ST_REQ;
                data_req_o   <= 1'b1;
                data_we_o    <= ex_mem_we_i;
                data_be_o    <= be_calc;
                data_addr_o  <= {ex_alu_result_i[XLEN-1:2], 2'b00};
                data_wdata_o <= wdata_calc;
                lat_we       <= ex_mem_we_i;
                lat_size     <= ex_mem_size_i;
                lat_sext     <= ex_mem_sext_i;
                lat_off      <= ex_alu_result_i[1:0];
                lat_rd       <= ex_rd_addr_i;
                lat_rd_we    <= ex_rd_we_i;
              end
            end else begin
              wb_valid_o   <= 1'b1;
              wb_rd_we_o   <= ex_rd_we_i;
              wb_rd_addr_o <= ex_rd_addr_i;
              wb_data_o    <= ex_alu_result_i;
            end
          end
        end
        ST_REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (data_rvalid_i) begin
            state_q      <= ST_IDLE;
            wb_valid_o   <= 1'b1;
            wb_rd_addr_o <= lat_rd;
            if (lat_we) begin
              wb_rd_we_o <= 1'b0;
            end else begin
              wb_rd_we_o <= lat_rd_we;
              wb_data_o  <= load_data;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
